// File: rtl/uart_readback_engine.sv
// UART read-back engine: decodes GET_RAM (0x11) / DSP_GET_REGS (0x21) and streams a status byte plus payload to TX.
// Optional trailing XOR checksum byte is enabled by defining UART_READBACK_CHECKSUM_EN.
module uart_readback_engine #(
   parameter int CLOCKS_PER_BIT = 40,
   parameter int READ_LATENCY   = 1,
   parameter int TX_SETTLE      = 2,
   parameter int DSP_REG_COUNT  = 128
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  in_uart_byte,
   input  logic        in_uart_byte_ready,
   input  logic        tx_uart_idle,
   output logic [7:0]  out_uart_byte,
   output logic        out_uart_byte_ready,
   output logic [15:0] ram_address,
   output logic        ram_re,
   input  logic [7:0]  ram_data_read,
   output logic [7:0]  dsp_reg_address,
   input  logic [7:0]  dsp_reg_data_out,
   output logic        busy
);

   localparam int TIMEOUT_CLKS = CLOCKS_PER_BIT * 12 * 512;
   localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TO_W-1:0] TO_LIMIT    = TO_W'(TIMEOUT_CLKS);
   localparam logic [2:0]      LAT_LAST    = 3'(READ_LATENCY);
   localparam logic [7:0]      SETTLE_LAST = (TX_SETTLE > 1) ? 8'(TX_SETTLE - 1) : 8'd0;
   localparam logic [8:0]      DSP_REM     = 9'(DSP_REG_COUNT);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_ARGS   = 4'd1,
      S_STATUS = 4'd2,
      S_FETCH  = 4'd3,
      S_SEND   = 4'd4,
      S_GAP    = 4'd5,
`ifdef UART_READBACK_CHECKSUM_EN
      S_CKSUM  = 4'd6,
`endif
      S_ERROR  = 4'd7,
      S_DONE   = 4'd8
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ram_addr_q, ram_addr_d;
   logic [7:0]  dsp_addr_q, dsp_addr_d;
   logic        ram_re_q, ram_re_d;
   logic [7:0]  out_byte_q, out_byte_d;
   logic        out_stb_q, out_stb_d;
   logic        busy_q, busy_d;
   logic        is_dsp_q, is_dsp_d;
   logic [8:0]  rem_q, rem_d;
   logic [1:0]  arg_idx_q, arg_idx_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [2:0]  lat_q, lat_d;
   logic [7:0]  settle_q, settle_d;
   logic [7:0]  data_q, data_d;
`ifdef UART_READBACK_CHECKSUM_EN
   logic [7:0]  xor_q, xor_d;
`endif

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         ram_addr_q <= 16'd0;
         dsp_addr_q <= 8'd0;
         ram_re_q   <= 1'b0;
         out_byte_q <= 8'd0;
         out_stb_q  <= 1'b0;
         busy_q     <= 1'b0;
         is_dsp_q   <= 1'b0;
         rem_q      <= 9'd0;
         arg_idx_q  <= 2'd0;
         to_cnt_q   <= '0;
         lat_q      <= 3'd0;
         settle_q   <= 8'd0;
         data_q     <= 8'd0;
`ifdef UART_READBACK_CHECKSUM_EN
         xor_q      <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         ram_addr_q <= ram_addr_d;
         dsp_addr_q <= dsp_addr_d;
         ram_re_q   <= ram_re_d;
         out_byte_q <= out_byte_d;
         out_stb_q  <= out_stb_d;
         busy_q     <= busy_d;
         is_dsp_q   <= is_dsp_d;
         rem_q      <= rem_d;
         arg_idx_q  <= arg_idx_d;
         to_cnt_q   <= to_cnt_d;
         lat_q      <= lat_d;
         settle_q   <= settle_d;
         data_q     <= data_d;
`ifdef UART_READBACK_CHECKSUM_EN
         xor_q      <= xor_d;
`endif
      end
   end

   // Next-state and next-output logic; outputs are registered from the next state.
   always_comb begin
      state_d    = state_q;
      ram_addr_d = ram_addr_q;
      dsp_addr_d = dsp_addr_q;
      out_byte_d = out_byte_q;
      out_stb_d  = 1'b0;
      is_dsp_d   = is_dsp_q;
      rem_d      = rem_q;
      arg_idx_d  = arg_idx_q;
      to_cnt_d   = to_cnt_q;
      lat_d      = lat_q;
      settle_d   = settle_q;
      data_d     = data_q;
`ifdef UART_READBACK_CHECKSUM_EN
      xor_d      = xor_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_uart_byte_ready && (in_uart_byte == 8'h11)) begin
               state_d   = S_ARGS;
               is_dsp_d  = 1'b0;
               arg_idx_d = 2'd0;
               to_cnt_d  = '0;
            end else if (in_uart_byte_ready && (in_uart_byte == 8'h21)) begin
               state_d    = S_STATUS;
               is_dsp_d   = 1'b1;
               dsp_addr_d = 8'd0;
               rem_d      = DSP_REM;
            end else begin
               state_d = S_IDLE;
            end
`ifdef UART_READBACK_CHECKSUM_EN
            xor_d = 8'd0;
`endif
         end
         S_ARGS: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (in_uart_byte_ready) begin
               arg_idx_d = arg_idx_q + 2'd1;
               case (arg_idx_q)
                  2'd0:    ram_addr_d[15:8] = in_uart_byte;
                  2'd1:    ram_addr_d[7:0]  = in_uart_byte;
                  2'd2: begin
                     rem_d   = {1'b0, in_uart_byte} + 9'd1;
                     state_d = S_STATUS;
                  end
                  default: arg_idx_d = 2'd0;
               endcase
            end else if (to_cnt_q >= TO_LIMIT) begin
               state_d = S_ERROR;
            end else begin
               state_d = S_ARGS;
            end
         end
         S_STATUS: begin
            if (tx_uart_idle) begin
               out_byte_d = 8'h00;
               out_stb_d  = 1'b1;
               settle_d   = 8'd0;
               state_d    = S_GAP;
            end else begin
               state_d = S_STATUS;
            end
         end
         S_FETCH: begin
            // Address has been stable since entry; data is valid READ_LATENCY clocks later.
            if (lat_q >= LAT_LAST) begin
               data_d  = is_dsp_q ? dsp_reg_data_out : ram_data_read;
               state_d = S_SEND;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         S_SEND: begin
            if (tx_uart_idle) begin
               out_byte_d = data_q;
               out_stb_d  = 1'b1;
               rem_d      = rem_q - 9'd1;
               settle_d   = 8'd0;
               state_d    = S_GAP;
`ifdef UART_READBACK_CHECKSUM_EN
               xor_d      = xor_q ^ data_q;
`endif
               if (is_dsp_q) begin
                  dsp_addr_d = dsp_addr_q + 8'd1;
               end else begin
                  ram_addr_d = ram_addr_q + 16'd1;
               end
            end else begin
               state_d = S_SEND;
            end
         end
         S_GAP: begin
            if (settle_q >= SETTLE_LAST) begin
               if (rem_q != 9'd0) begin
                  lat_d   = 3'd0;
                  state_d = S_FETCH;
               end else begin
`ifdef UART_READBACK_CHECKSUM_EN
                  state_d = S_CKSUM;
`else
                  state_d = S_DONE;
`endif
               end
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
`ifdef UART_READBACK_CHECKSUM_EN
         S_CKSUM: begin
            if (tx_uart_idle) begin
               out_byte_d = xor_q;
               out_stb_d  = 1'b1;
               state_d    = S_DONE;
            end else begin
               state_d = S_CKSUM;
            end
         end
`endif
         S_ERROR: begin
            if (tx_uart_idle) begin
               out_byte_d = 8'hFF;
               out_stb_d  = 1'b1;
               state_d    = S_DONE;
            end else begin
               state_d = S_ERROR;
            end
         end
         S_DONE: begin
            is_dsp_d   = 1'b0;
            ram_addr_d = 16'd0;
            dsp_addr_d = 8'd0;
            rem_d      = 9'd0;
            arg_idx_d  = 2'd0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      ram_re_d = (state_d == S_FETCH) && !is_dsp_d;
      busy_d   = (state_d != S_IDLE);
   end

   assign out_uart_byte       = out_byte_q;
   assign out_uart_byte_ready = out_stb_q;
   assign ram_address         = ram_addr_q;
   assign ram_re              = ram_re_q;
   assign dsp_reg_address     = dsp_addr_q;
   assign busy                = busy_q;

endmodule

// File: tb/tb_uart_readback_engine.sv
// Scoreboard bench for uart_readback_engine: stimulus pushes expected TX bytes, a monitor pops and compares.
module tb_uart_readback_engine;

   localparam int CPB  = 2;
   localparam int RL   = 1;
   localparam int TS   = 2;
   localparam int NREG = 128;
`ifdef UART_READBACK_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic [7:0]  in_uart_byte;
   logic        in_uart_byte_ready;
   logic        tx_uart_idle;
   logic [7:0]  out_uart_byte;
   logic        out_uart_byte_ready;
   logic [15:0] ram_address;
   logic        ram_re;
   logic [7:0]  ram_data_read;
   logic [7:0]  dsp_reg_address;
   logic [7:0]  dsp_reg_data_out;
   logic        busy;

   logic [7:0]  mem [0:65535];
   logic [7:0]  exp_q [$];
   logic [15:0] addr_q [$];
   logic [7:0]  ck;
   int          n_tests = 0;
   int          n_fail = 0;
   int          strobe_cnt = 0;
   int          tx_busy = 0;
   logic        tx_hold = 1'b0;
   int          cyc = 0;
   int          last_stb = -1;
   logic        ram_re_prev = 1'b0;

   always #5 clock = ~clock;

   uart_readback_engine #(
      .CLOCKS_PER_BIT(CPB), .READ_LATENCY(RL), .TX_SETTLE(TS), .DSP_REG_COUNT(NREG)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .in_uart_byte(in_uart_byte), .in_uart_byte_ready(in_uart_byte_ready),
      .tx_uart_idle(tx_uart_idle),
      .out_uart_byte(out_uart_byte), .out_uart_byte_ready(out_uart_byte_ready),
      .ram_address(ram_address), .ram_re(ram_re), .ram_data_read(ram_data_read),
      .dsp_reg_address(dsp_reg_address), .dsp_reg_data_out(dsp_reg_data_out),
      .busy(busy)
   );

   assign tx_uart_idle = (tx_busy == 0) && !tx_hold;

   // One-cycle-latency RAM and DSP register file models (DSP reg k holds k^0x80).
   always @(posedge clock) begin
      ram_data_read    <= mem[ram_address];
      dsp_reg_data_out <= dsp_reg_address ^ 8'h80;
      cyc              <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_status();
      exp_q.push_back(8'h00);
      ck = 8'h00;
   endtask
   task automatic exp_data(input logic [7:0] b);
      exp_q.push_back(b);
      ck = ck ^ b;
   endtask
   task automatic exp_end();
      if (CK == 1) exp_q.push_back(ck);
   endtask

   // TX core model: busy for a few cycles after each strobe; also checks strobe spacing.
   initial begin
      forever begin
         @(negedge clock);
         if (out_uart_byte_ready === 1'b1) begin
            if (last_stb >= 0) begin
               n_tests++;
               if ((cyc - last_stb) < TS + 1) begin
                  n_fail++;
                  $display("FAIL strobe_spacing: got %0d cycles required >= %0d", cyc - last_stb, TS + 1);
               end
            end
            last_stb = cyc;
            strobe_cnt++;
            tx_busy = 6;
         end else if (tx_busy > 0) begin
            tx_busy--;
         end
      end
   end

   // Monitor: compares every transmitted byte and every RAM fetch address against the scoreboard.
   initial begin
      forever begin
         @(negedge clock);
         if (reset_n && ram_re && !ram_re_prev && addr_q.size() > 0)
            check("ram_address", {16'd0, ram_address}, {16'd0, addr_q.pop_front()});
         ram_re_prev = ram_re;
         if (out_uart_byte_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL tx_unexpected: got %02h expected no byte", out_uart_byte);
            end else begin
               check("tx_byte", {24'd0, out_uart_byte}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      in_uart_byte       = b;
      in_uart_byte_ready = 1'b1;
      @(negedge clock);
      in_uart_byte_ready = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (!busy && exp_q.size() == 0) break;
      end
      check({name, "_drained"}, exp_q.size(), 32'd0);
      check({name, "_addr_drained"}, addr_q.size(), 32'd0);
      check({name, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_out_byte"}, {24'd0, out_uart_byte}, 32'd0);
      check({name, "_out_stb"}, {31'd0, out_uart_byte_ready}, 32'd0);
      check({name, "_ram_address"}, {16'd0, ram_address}, 32'd0);
      check({name, "_ram_re"}, {31'd0, ram_re}, 32'd0);
      check({name, "_dsp_addr"}, {24'd0, dsp_reg_address}, 32'd0);
      check({name, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int base;
      reset_n            = 1'b0;
      in_uart_byte       = 8'h00;
      in_uart_byte_ready = 1'b0;
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'h1234] = 8'hAA; mem[16'h1235] = 8'hBB; mem[16'h1236] = 8'hCC;
      mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;
      for (int a = 0; a < 16; a++) mem[16'h0100 + a] = 8'h30 + 8'(a);
      repeat (4) @(negedge clock);
      check_outputs_zero("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Basic 3-byte RAM read.
      exp_status(); exp_data(8'hAA); exp_data(8'hBB); exp_data(8'hCC); exp_end();
      addr_q.push_back(16'h1234); addr_q.push_back(16'h1235); addr_q.push_back(16'h1236);
      send_byte(8'h11); send_byte(8'h12); send_byte(8'h34); send_byte(8'h02);
      check("busy_after_cmd", {31'd0, busy}, 32'd1);
      wait_done("ram3", 2000);

      // Address wrap 0xFFFF -> 0x0000.
      exp_status(); exp_data(8'h5A); exp_data(8'hA5); exp_end();
      addr_q.push_back(16'hFFFF); addr_q.push_back(16'h0000);
      send_byte(8'h11); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01);
      wait_done("wrap", 2000);

      // Unknown opcode is ignored.
      send_byte(8'h55);
      repeat (20) @(negedge clock);
      check("unknown_busy", {31'd0, busy}, 32'd0);

      // DSP register dump.
      exp_status();
      for (int k = 0; k < NREG; k++) exp_data(8'(k) ^ 8'h80);
      exp_end();
      send_byte(8'h21);
      wait_done("dsp", 5000);

      // Argument timeout: nothing may come out early, then a single 0xFF.
      send_byte(8'h11); send_byte(8'h12);
      repeat (12000) @(negedge clock);
      check("timeout_still_busy", {31'd0, busy}, 32'd1);
      exp_q.push_back(8'hFF);
      wait_done("timeout", 2000);
      exp_status(); exp_data(8'hA5); exp_end();
      addr_q.push_back(16'h0000);
      send_byte(8'h11); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      wait_done("after_timeout", 2000);

      // TX held not-idle: no strobes until released.
      tx_hold = 1'b1;
      base = strobe_cnt;
      exp_status(); exp_data(8'hAA); exp_data(8'hBB); exp_data(8'hCC); exp_end();
      send_byte(8'h11); send_byte(8'h12); send_byte(8'h34); send_byte(8'h02);
      repeat (1000) @(negedge clock);
      check("hold_no_strobe", strobe_cnt - base, 32'd0);
      tx_hold = 1'b0;
      wait_done("hold", 2000);
      check("hold_strobe_count", strobe_cnt - base, 32'(4 + CK));

      // Reset after the 2nd payload byte of a 16-byte read.
      base = strobe_cnt;
      exp_status(); exp_data(8'h30); exp_data(8'h31);
      send_byte(8'h11); send_byte(8'h01); send_byte(8'h00); send_byte(8'h0F);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         if (strobe_cnt >= base + 3) break;
      end
      check("pre_reset_strobes", strobe_cnt - base, 32'd3);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      check_outputs_zero("mid_reset");
      check("mid_reset_exp_left", exp_q.size(), 32'd0);
      reset_n = 1'b1;
      repeat (200) @(negedge clock);
      check("post_reset_strobes", strobe_cnt - base, 32'd3);
      exp_status(); exp_data(8'hAA); exp_end();
      addr_q.push_back(16'h1234);
      send_byte(8'h11); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
      wait_done("after_reset", 2000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
